// File: rtl/game_controller.sv
// Pinball game sequencer: walks WELCOME/SERVE/PLAY/LOST/END on frame boundaries
// and owns the life counter and the saturating 4-digit score.
module game_controller #(
  parameter int LIVES_INIT  = 3,
  parameter int LOST_FRAMES = 60,
  parameter int SCORE_MAX   = 9999
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        startOfFrame,
  input  logic        key_start,
  input  logic        ball_lost,
  input  logic        score_add_valid,
  input  logic [3:0]  score_add,
  output logic [1:0]  screen_sel,
  output logic        game_run,
  output logic        ball_reset,
  output logic [2:0]  lives,
  output logic [13:0] score
);

  typedef enum logic [2:0] {
    ST_WELCOME,
    ST_SERVE,
    ST_PLAY,
    ST_LOST,
    ST_END
  } state_t;

  localparam logic [2:0]  LIVES_LOAD = 3'(LIVES_INIT);
  localparam logic [7:0]  FRAME_LAST = 8'(LOST_FRAMES - 1);
  localparam logic [14:0] SCORE_CAP  = 15'(SCORE_MAX);

  state_t      state, state_next;
  logic [2:0]  lives_next;
  logic [13:0] score_next;
  logic [7:0]  frame_cnt, frame_next;
  logic        key_prev;
  logic        key_rise;
  logic [14:0] score_sum;

  // key_prev starts high so a key held through reset is not taken as a press
  assign key_rise  = key_start & ~key_prev;
  assign score_sum = {1'b0, score} + {11'd0, score_add};

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= ST_WELCOME;
      lives     <= '0;
      score     <= '0;
      frame_cnt <= '0;
      key_prev  <= 1'b1;
    end else begin
      state     <= state_next;
      lives     <= lives_next;
      score     <= score_next;
      frame_cnt <= frame_next;
      key_prev  <= key_start;
    end
  end

  always_comb begin
    state_next = state;
    lives_next = lives;
    score_next = score;
    frame_next = frame_cnt;
    case (state)
      ST_WELCOME: begin
        if (key_rise) begin
          state_next = ST_SERVE;
          lives_next = LIVES_LOAD;
          score_next = '0;
        end
      end
      ST_SERVE: begin
        if (startOfFrame) state_next = ST_PLAY;
      end
      ST_PLAY: begin
        // Score and life updates are independent so a simultaneous hit and loss both land
        if (score_add_valid)
          score_next = (score_sum > SCORE_CAP) ? SCORE_CAP[13:0] : score_sum[13:0];
        if (ball_lost) begin
          if (lives > 3'd1) begin
            lives_next = lives - 3'd1;
            frame_next = '0;
            state_next = ST_LOST;
          end else begin
            lives_next = '0;
            state_next = ST_END;
          end
        end
      end
      ST_LOST: begin
        if (startOfFrame) begin
          frame_next = frame_cnt + 8'd1;
          if (frame_cnt == FRAME_LAST) state_next = ST_SERVE;
        end
      end
      ST_END: begin
        if (key_rise) state_next = ST_WELCOME;
      end
      default: state_next = ST_WELCOME;
    endcase
  end

  always_comb begin
    screen_sel = 2'd1;
    game_run   = 1'b0;
    ball_reset = 1'b0;
    case (state)
      ST_WELCOME: screen_sel = 2'd0;
      ST_END:     screen_sel = 2'd2;
      ST_PLAY:    game_run   = 1'b1;
      ST_SERVE:   ball_reset = 1'b1;
      default:    screen_sel = 2'd1;
    endcase
  end

endmodule

// File: tb/tb_game_controller.sv
// Directed bench for game_controller: walks full games through serve, loss,
// saturation, end and mid-game reset with hand-computed expectations.
module tb_game_controller;

  logic        clk = 1'b0;
  logic        reset;
  logic        startOfFrame;
  logic        key_start;
  logic        ball_lost;
  logic        score_add_valid;
  logic [3:0]  score_add;
  logic [1:0]  screen_sel;
  logic        game_run;
  logic        ball_reset;
  logic [2:0]  lives;
  logic [13:0] score;

  int vector_count = 0;
  int miss_count   = 0;

  game_controller #(
    .LIVES_INIT(3),
    .LOST_FRAMES(60),
    .SCORE_MAX(9999)
  ) dut (
    .clk(clk),
    .reset(reset),
    .startOfFrame(startOfFrame),
    .key_start(key_start),
    .ball_lost(ball_lost),
    .score_add_valid(score_add_valid),
    .score_add(score_add),
    .screen_sel(screen_sel),
    .game_run(game_run),
    .ball_reset(ball_reset),
    .lives(lives),
    .score(score)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input int observed, input int expected);
    vector_count++;
    if (observed !== expected) begin
      miss_count++;
      $display("[TB] FAIL %s: got %0d, expected %0d", tag, observed, expected);
    end
  endtask

  // One clock cycle with the given inputs; pulses drop afterwards, the key stays as set
  task automatic applyStimulus(input logic sof, input logic key, input logic lost,
                               input logic add_valid, input logic [3:0] add);
    startOfFrame    = sof;
    key_start       = key;
    ball_lost       = lost;
    score_add_valid = add_valid;
    score_add       = add;
    tick();
    startOfFrame    = 1'b0;
    ball_lost       = 1'b0;
    score_add_valid = 1'b0;
    score_add       = 4'd0;
  endtask

  task automatic sofFrames(input int n);
    for (int i = 0; i < n; i++) applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 4'd0);
  endtask

  initial begin
    reset = 1'b1; startOfFrame = 1'b0; key_start = 1'b1;
    ball_lost = 1'b0; score_add_valid = 1'b0; score_add = 4'd0;
    tick(); tick();
    reset = 1'b0;
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 4'd0);
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 4'd0);
    checkOutput("held_key_screen", screen_sel, 0);
    checkOutput("rst_game_run", game_run, 0);
    checkOutput("rst_ball_reset", ball_reset, 0);
    checkOutput("rst_lives", lives, 0);
    checkOutput("rst_score", score, 0);

    // Game 1: release then press starts serve
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 4'd0);
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 4'd0);
    checkOutput("serve_screen", screen_sel, 1);
    checkOutput("serve_ball_reset", ball_reset, 1);
    checkOutput("serve_lives", lives, 3);
    checkOutput("serve_score", score, 0);
    checkOutput("serve_game_run", game_run, 0);
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 4'd0);
    checkOutput("play_game_run", game_run, 1);
    checkOutput("play_ball_reset", ball_reset, 0);

    for (int i = 0; i < 3; i++) applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 4'd5);
    checkOutput("score_15", score, 15);
    for (int i = 0; i < 665; i++) applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 4'd15);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 4'd5);
    checkOutput("score_9995", score, 9995);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 4'd9);
    checkOutput("score_sat_9", score, 9999);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 4'd15);
    checkOutput("score_sat_15", score, 9999);

    applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 4'd0);
    checkOutput("lost1_lives", lives, 2);
    checkOutput("lost1_game_run", game_run, 0);
    checkOutput("lost1_screen", screen_sel, 1);
    sofFrames(59);
    checkOutput("lost59_ball_reset", ball_reset, 0);
    checkOutput("lost59_game_run", game_run, 0);
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 4'd0);
    checkOutput("lost_ignore_lives", lives, 2);
    sofFrames(1);
    checkOutput("lost60_serve", ball_reset, 1);
    sofFrames(1);
    checkOutput("reserve_play", game_run, 1);

    applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 4'd0);
    checkOutput("lost2_lives", lives, 1);
    sofFrames(60);
    sofFrames(1);
    checkOutput("play3_game_run", game_run, 1);
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 4'd0);
    checkOutput("end1_screen", screen_sel, 2);
    checkOutput("end1_lives", lives, 0);
    checkOutput("end1_score", score, 9999);
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 4'd0);
    checkOutput("end1_welcome", screen_sel, 0);
    checkOutput("welcome_score_kept", score, 9999);
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b1, 4'd3);
    checkOutput("welcome_ignore_lives", lives, 0);
    checkOutput("welcome_ignore_screen", screen_sel, 0);

    // Game 2: small score so ignored adds are visible
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 4'd0);
    checkOutput("g2_score_clear", score, 0);
    checkOutput("g2_lives", lives, 3);
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 4'd0);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 4'd4);
    checkOutput("g2_score_4", score, 4);
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 4'd0);
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b1, 4'd3);
    checkOutput("g2_lost_ign_score", score, 4);
    checkOutput("g2_lost_ign_lives", lives, 2);
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 4'd0);
    checkOutput("g2_lost_ign_key", screen_sel, 1);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 4'd0);
    sofFrames(60);
    sofFrames(1);
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 4'd0);
    sofFrames(60);
    sofFrames(1);
    checkOutput("g2_last_life", lives, 1);
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b1, 4'd7);
    checkOutput("g2_simul_score", score, 11);
    checkOutput("g2_simul_lives", lives, 0);
    checkOutput("g2_simul_screen", screen_sel, 2);
    checkOutput("g2_end_game_run", game_run, 0);
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b1, 4'd6);
    checkOutput("g2_end_ign_score", score, 11);
    checkOutput("g2_end_ign_lives", lives, 0);
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 4'd0);
    checkOutput("g2_end_welcome", screen_sel, 0);

    // Game 3: reset in the middle of LOST
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 4'd0);
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 4'd0);
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 4'd0);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 4'd2);
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 4'd0);
    sofFrames(10);
    checkOutput("g3_lost_screen", screen_sel, 1);
    reset = 1'b1;
    applyStimulus(1'b1, 1'b0, 1'b1, 1'b1, 4'd9);
    reset = 1'b0;
    checkOutput("midrst_screen", screen_sel, 0);
    checkOutput("midrst_game_run", game_run, 0);
    checkOutput("midrst_ball_reset", ball_reset, 0);
    checkOutput("midrst_lives", lives, 0);
    checkOutput("midrst_score", score, 0);
    checkOutput("midrst_frame_cnt", int'(dut.frame_cnt), 0);
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 4'd0);
    checkOutput("midrst_stays_welcome", screen_sel, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vector_count, miss_count);
    $finish;
  end

endmodule
